// File: rtl/id_ex_pkg.sv
// Shared definitions for the ID/EX stage: control-bundle bit positions,
// instruction classes and the class decoder.
package id_ex_pkg;

  localparam int REG_DST    = 7;
  localparam int JUMP       = 6;
  localparam int BRANCH     = 5;
  localparam int MEM_READ   = 4;
  localparam int MEM_TO_REG = 3;
  localparam int MEM_WRITE  = 2;
  localparam int ALU_SRC    = 1;
  localparam int REG_WRITE  = 0;

  typedef enum logic [2:0] {
    CLS_R    = 3'd0,
    CLS_I    = 3'd1,
    CLS_BR   = 3'd2,
    CLS_ST   = 3'd3,
    CLS_NONE = 3'd4
  } insn_cls_e;

  // Only {reg_dst, reg_write, branch, mem_write} select the class; the rest ride along.
  function automatic insn_cls_e classify(input logic [7:0] ctrl);
    logic [3:0] key;
    key = {ctrl[REG_DST], ctrl[REG_WRITE], ctrl[BRANCH], ctrl[MEM_WRITE]};
    case (key)
      4'b1100: classify = CLS_R;
      4'b0100: classify = CLS_I;
      4'b0010: classify = CLS_BR;
      4'b0001: classify = CLS_ST;
      default: classify = CLS_NONE;
    endcase
  endfunction

endpackage

// File: rtl/id_ex_stage_reg_regfile.sv
// Architectural register file: 2 combinational read ports, 1 synchronous write
// port, asynchronous clear. Optional hard-wired zero register.
module regfile_2r1w #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 4,
  parameter int ZERO_REG   = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] raddr1,
  input  logic [REG_ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0]     rdata1,
  output logic [DATA_W-1:0]     rdata2,
  input  logic                  we,
  input  logic [REG_ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0]     wdata
);

  localparam int DEPTH = 2 ** REG_ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic              wr_en_s;

  assign wr_en_s = we && !((ZERO_REG != 0) && (waddr == {REG_ADDR_W{1'b0}}));

  // Next-state of the array: one entry updated on an accepted write.
  always_comb begin
    mem_d = mem_q;
    if (wr_en_s) begin
      mem_d[waddr] = wdata;
    end else begin
      mem_d = mem_q;
    end
  end

  // Storage with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {DATA_W{1'b0}};
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rdata1 = ((ZERO_REG != 0) && (raddr1 == {REG_ADDR_W{1'b0}})) ? {DATA_W{1'b0}} : mem_q[raddr1];
  assign rdata2 = ((ZERO_REG != 0) && (raddr2 == {REG_ADDR_W{1'b0}})) ? {DATA_W{1'b0}} : mem_q[raddr2];

endmodule

// File: rtl/id_ex_stage_reg.sv
// Decode-to-execute stage: register file, operand/immediate selection and the
// ID/EX pipeline register. Define ID_EX_WB_BYPASS_EN to forward same-edge write-back data.
module id_ex_stage_reg
  import id_ex_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 4,
  parameter int IMM_W      = 8,
  parameter int IMM_SIGNED = 0,
  parameter int ZERO_REG   = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] rs,
  input  logic [REG_ADDR_W-1:0] rt,
  input  logic [REG_ADDR_W-1:0] rd,
  input  logic [IMM_W-1:0]      imm,
  input  logic [7:0]            ctrl_in,
  input  logic                  valid_in,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  wb_we,
  input  logic [REG_ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0]     wb_data,
  output logic [7:0]            ctrl_out,
  output logic                  valid_out,
  output logic [REG_ADDR_W-1:0] rd_out,
  output logic [DATA_W-1:0]     read_data1,
  output logic [DATA_W-1:0]     read_data2,
  output logic [DATA_W-1:0]     imm_value
);

  insn_cls_e             cls_s;
  logic [REG_ADDR_W-1:0] ra1_s;
  logic [DATA_W-1:0]     rf_rd1_s, rf_rd2_s;
  logic [DATA_W-1:0]     op1_s, op2_s;
  logic [DATA_W-1:0]     imm_ext_s;

  logic [7:0]            ctrl_q, ctrl_d;
  logic                  valid_q, valid_d;
  logic [REG_ADDR_W-1:0] rd_q, rd_d;
  logic [DATA_W-1:0]     rd1_q, rd1_d;
  logic [DATA_W-1:0]     rd2_q, rd2_d;
  logic [DATA_W-1:0]     imm_q, imm_d;

  assign cls_s = classify(ctrl_in);
  // I-type carries its single register source in rt.
  assign ra1_s = (cls_s == CLS_I) ? rt : rs;
  assign imm_ext_s = (IMM_SIGNED != 0) ? DATA_W'($signed(imm)) : DATA_W'(imm);

  regfile_2r1w #(
    .DATA_W    (DATA_W),
    .REG_ADDR_W(REG_ADDR_W),
    .ZERO_REG  (ZERO_REG)
  ) u_rf (
    .clk   (clk),
    .rst   (rst),
    .raddr1(ra1_s),
    .raddr2(rt),
    .rdata1(rf_rd1_s),
    .rdata2(rf_rd2_s),
    .we    (wb_we),
    .waddr (wb_addr),
    .wdata (wb_data)
  );

`ifdef ID_EX_WB_BYPASS_EN
  logic byp1_s, byp2_s;
  assign byp1_s = wb_we && (wb_addr == ra1_s) &&
                  !((ZERO_REG != 0) && (ra1_s == {REG_ADDR_W{1'b0}}));
  assign byp2_s = wb_we && (wb_addr == rt) &&
                  !((ZERO_REG != 0) && (rt == {REG_ADDR_W{1'b0}}));
  assign op1_s = byp1_s ? wb_data : rf_rd1_s;
  assign op2_s = byp2_s ? wb_data : rf_rd2_s;
`else
  assign op1_s = rf_rd1_s;
  assign op2_s = rf_rd2_s;
`endif

  // Pipeline register next-state: flush beats stall, stall beats load; invalid loads are bubbles.
  always_comb begin
    ctrl_d  = ctrl_q;
    valid_d = valid_q;
    rd_d    = rd_q;
    rd1_d   = rd1_q;
    rd2_d   = rd2_q;
    imm_d   = imm_q;
    if (flush || (!stall && !valid_in)) begin
      ctrl_d  = 8'h00;
      valid_d = 1'b0;
      rd_d    = {REG_ADDR_W{1'b0}};
      rd1_d   = {DATA_W{1'b0}};
      rd2_d   = {DATA_W{1'b0}};
      imm_d   = {DATA_W{1'b0}};
    end else if (stall) begin
      ctrl_d  = ctrl_q;
      valid_d = valid_q;
    end else begin
      ctrl_d  = ctrl_in;
      valid_d = 1'b1;
      rd_d    = rd;
      case (cls_s)
        CLS_R: begin
          rd1_d = op1_s;
          rd2_d = op2_s;
          imm_d = {DATA_W{1'b0}};
        end
        CLS_I: begin
          rd1_d = op1_s;
          rd2_d = {DATA_W{1'b0}};
          imm_d = imm_ext_s;
        end
        CLS_BR, CLS_ST: begin
          rd1_d = op1_s;
          rd2_d = op2_s;
          imm_d = imm_ext_s;
        end
        default: begin
          rd1_d = {DATA_W{1'b0}};
          rd2_d = {DATA_W{1'b0}};
          imm_d = {DATA_W{1'b0}};
        end
      endcase
    end
  end

  // ID/EX register bank.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_q  <= 8'h00;
      valid_q <= 1'b0;
      rd_q    <= {REG_ADDR_W{1'b0}};
      rd1_q   <= {DATA_W{1'b0}};
      rd2_q   <= {DATA_W{1'b0}};
      imm_q   <= {DATA_W{1'b0}};
    end else begin
      ctrl_q  <= ctrl_d;
      valid_q <= valid_d;
      rd_q    <= rd_d;
      rd1_q   <= rd1_d;
      rd2_q   <= rd2_d;
      imm_q   <= imm_d;
    end
  end

  assign ctrl_out   = ctrl_q;
  assign valid_out  = valid_q;
  assign rd_out     = rd_q;
  assign read_data1 = rd1_q;
  assign read_data2 = rd2_q;
  assign imm_value  = imm_q;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Scoreboard bench for id_ex_stage_reg (IMM_SIGNED=1, ZERO_REG=1): driver pushes
// hand-computed expectations, a monitor pops one per clock and compares.
module tb_id_ex_stage_reg;

  localparam int DW = 32;
  localparam int AW = 4;
  localparam int IW = 8;

  logic          clk;
  logic          rst;
  logic [AW-1:0] rs, rt, rd, wb_addr, rd_out;
  logic [IW-1:0] imm;
  logic [7:0]    ctrl_in, ctrl_out;
  logic          valid_in, stall, flush, wb_we, valid_out;
  logic [DW-1:0] wb_data, read_data1, read_data2, imm_value;

  typedef struct {
    int            id;
    logic [7:0]    ctrl;
    logic          valid;
    logic [AW-1:0] rd;
    logic [DW-1:0] d1;
    logic [DW-1:0] d2;
    logic [DW-1:0] imm;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_push   = 0;

  id_ex_stage_reg #(
    .DATA_W(DW), .REG_ADDR_W(AW), .IMM_W(IW), .IMM_SIGNED(1), .ZERO_REG(1)
  ) dut (
    .clk(clk), .rst(rst), .rs(rs), .rt(rt), .rd(rd), .imm(imm),
    .ctrl_in(ctrl_in), .valid_in(valid_in), .stall(stall), .flush(flush),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .ctrl_out(ctrl_out), .valid_out(valid_out), .rd_out(rd_out),
    .read_data1(read_data1), .read_data2(read_data2), .imm_value(imm_value)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input exp_t e);
    n_checks++;
    if (ctrl_out !== e.ctrl || valid_out !== e.valid || rd_out !== e.rd ||
        read_data1 !== e.d1 || read_data2 !== e.d2 || imm_value !== e.imm) begin
      $display("FAIL chk%0d: got ctrl=%h valid=%b rd=%h d1=%h d2=%h imm=%h, want ctrl=%h valid=%b rd=%h d1=%h d2=%h imm=%h",
               e.id, ctrl_out, valid_out, rd_out, read_data1, read_data2, imm_value,
               e.ctrl, e.valid, e.rd, e.d1, e.d2, e.imm);
    end else begin
      n_pass++;
    end
  endtask

  task automatic push(input logic [7:0] c, input logic v, input logic [AW-1:0] d,
                      input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [DW-1:0] i);
    exp_t e;
    e.id = n_push; e.ctrl = c; e.valid = v; e.rd = d; e.d1 = a; e.d2 = b; e.imm = i;
    n_push++;
    sb_q.push_back(e);
  endtask

  task automatic bubble();
    push(8'h00, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0);
  endtask

  task automatic idle();
    valid_in = 1'b0; stall = 1'b0; flush = 1'b0; wb_we = 1'b0;
    ctrl_in = 8'h00; rs = 4'h0; rt = 4'h0; rd = 4'h0; imm = 8'h00;
    wb_addr = 4'h0; wb_data = 32'h0;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    idle();
    wb_we = 1'b1; wb_addr = a; wb_data = d;
    bubble();
  endtask

  task automatic load(input logic [7:0] c, input logic [AW-1:0] s, input logic [AW-1:0] t,
                      input logic [AW-1:0] d, input logic [IW-1:0] i);
    @(negedge clk);
    idle();
    valid_in = 1'b1; ctrl_in = c; rs = s; rt = t; rd = d; imm = i;
  endtask

  // Monitor: one registered result per edge, compared away from the edge.
  always @(posedge clk) begin
    #2;
    if (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      check(mon_e);
    end
  end

  initial begin
    exp_t z;
    z.id = -1; z.ctrl = 8'h00; z.valid = 1'b0; z.rd = 4'h0;
    z.d1 = 32'h0; z.d2 = 32'h0; z.imm = 32'h0;

    rst = 1'b1;
    idle();
    repeat (2) @(negedge clk);
    check(z);
    rst = 1'b0;

    // Reset mid-run clears both pipeline register and register file.
    wr(4'd3, 32'h55);
    load(8'h81, 4'd3, 4'd3, 4'd7, 8'h00);
    push(8'h81, 1'b1, 4'd7, 32'h55, 32'h55, 32'h0);
    @(negedge clk);
    idle();
    #2 rst = 1'b1;
    #1;
    z.id = -2;
    check(z);
    @(negedge clk);
    rst = 1'b0;
    valid_in = 1'b1; ctrl_in = 8'h81; rs = 4'd3; rt = 4'd3; rd = 4'd7;
    push(8'h81, 1'b1, 4'd7, 32'h0, 32'h0, 32'h0);

    wr(4'd1, 32'd10);
    wr(4'd2, 32'd20);
    wr(4'd4, 32'd7);
    wr(4'd5, 32'd1);
    wr(4'd0, 32'h1234);

    load(8'h81, 4'd1, 4'd2, 4'd9, 8'h00);
    push(8'h81, 1'b1, 4'd9, 32'd10, 32'd20, 32'h0);
    load(8'h01, 4'd1, 4'd4, 4'd6, 8'hF0);
    push(8'h01, 1'b1, 4'd6, 32'd7, 32'h0, 32'hFFFF_FFF0);
    load(8'h20, 4'd1, 4'd2, 4'd0, 8'h05);
    push(8'h20, 1'b1, 4'd0, 32'd10, 32'd20, 32'h5);

    // Stall with changing inputs; write-back still lands during the stall.
    for (int k = 0; k < 3; k++) begin
      load(8'h81, 4'(k + 2), 4'(k + 1), 4'(k + 10), 8'(k * 3));
      stall = 1'b1;
      if (k == 1) begin
        wb_we = 1'b1; wb_addr = 4'd6; wb_data = 32'h66;
      end
      push(8'h20, 1'b1, 4'd0, 32'd10, 32'd20, 32'h5);
    end
    load(8'h81, 4'd1, 4'd2, 4'd9, 8'h00);
    stall = 1'b1; flush = 1'b1;
    bubble();

    // Same-edge write and read of RF[5].
    load(8'h04, 4'd5, 4'd2, 4'd3, 8'h7F);
    wb_we = 1'b1; wb_addr = 4'd5; wb_data = 32'd99;
`ifdef ID_EX_WB_BYPASS_EN
    push(8'h04, 1'b1, 4'd3, 32'd99, 32'd20, 32'h7F);
`else
    push(8'h04, 1'b1, 4'd3, 32'd1, 32'd20, 32'h7F);
`endif
    load(8'h04, 4'd5, 4'd2, 4'd3, 8'h80);
    push(8'h04, 1'b1, 4'd3, 32'd99, 32'd20, 32'hFFFF_FF80);

    // Register 0 stays zero, even with a same-edge write to it.
    load(8'h81, 4'd0, 4'd6, 4'd1, 8'h00);
    push(8'h81, 1'b1, 4'd1, 32'h0, 32'h66, 32'h0);
    load(8'h81, 4'd0, 4'd2, 4'd2, 8'h00);
    wb_we = 1'b1; wb_addr = 4'd0; wb_data = 32'hABCD;
    push(8'h81, 1'b1, 4'd2, 32'h0, 32'd20, 32'h0);

    // Unrecognised class, invalid slot, plain stall, plain flush.
    load(8'hA1, 4'd1, 4'd2, 4'd5, 8'h12);
    push(8'hA1, 1'b1, 4'd5, 32'h0, 32'h0, 32'h0);
    load(8'h81, 4'd1, 4'd2, 4'd4, 8'h00);
    valid_in = 1'b0;
    bubble();
    load(8'h20, 4'd2, 4'd1, 4'd8, 8'h7F);
    push(8'h20, 1'b1, 4'd8, 32'd20, 32'd10, 32'h7F);
    load(8'h01, 4'd3, 4'd4, 4'd1, 8'h01);
    stall = 1'b1;
    push(8'h20, 1'b1, 4'd8, 32'd20, 32'd10, 32'h7F);
    load(8'h01, 4'd3, 4'd4, 4'd1, 8'h01);
    flush = 1'b1;
    bubble();

    @(negedge clk);
    idle();
    repeat (3) @(negedge clk);
    if (sb_q.size() != 0) begin
      n_checks++;
      $display("FAIL drain: got %0d pending, want 0", sb_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want $finish");
    $fatal(1);
  end

endmodule

// File: doc/id_ex_stage_reg.md
Name: id_ex_stage_reg

Overview:
- Parametrised decode-to-execute stage: owns the architectural register file (2 read ports, 1 write-back port) and the ID/EX pipeline register.
- Decodes the instruction class from control bits, selects operands and immediate, and registers them with control and a valid bit for the EX stage.
- Adds reset, flush/bubble insertion, a stall hold and an optional write-back bypass.

Parameters:
- DATA_W, 32, register/operand width.
- REG_ADDR_W, 4, register index width; register file depth is 2**REG_ADDR_W.
- IMM_W, 8, raw immediate width; must be ≤ DATA_W.
- IMM_SIGNED, 0, 1 = sign-extend immediate, 0 = zero-extend.
- ZERO_REG, 0, 1 = register 0 reads as 0 and ignores writes.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-high reset
- rs  in  REG_ADDR_W  source index A
- rt  in  REG_ADDR_W  source index B
- rd  in  REG_ADDR_W  destination index (passed through)
- imm  in  IMM_W  raw immediate
- ctrl_in  in  8  control bundle; bit map in package
- valid_in  in  1  ID holds a real instruction
- stall  in  1  hold pipeline register
- flush  in  1  insert bubble
- wb_we  in  1  write-back enable
- wb_addr  in  REG_ADDR_W  write-back index
- wb_data  in  DATA_W  write-back data
- ctrl_out  out  8  registered control bundle
- valid_out  out  1  registered valid
- rd_out  out  REG_ADDR_W  registered destination
- read_data1  out  DATA_W  operand A
- read_data2  out  DATA_W  operand B
- imm_value  out  DATA_W  extended immediate

Behaviour:
- Reset (async, rst=1): every output 0; all register file entries 0. This holds while rst is high and overrides every other input.
- Latency: 1 cycle. Outputs update only on posedge clk.
- Priority per edge:
  - flush: valid_out=0, ctrl_out=0, data outputs 0.
  - else stall: all outputs hold.
  - else load.
- Load when valid_in=0: load a bubble, same as flush.
- Load, class decode on ctrl_in {reg_dst, reg_write, branch, mem_write}:
  - R (1,1,0,0): rd1=RF[rs], rd2=RF[rt], imm_value=0.
  - I (0,1,0,0): rd1=RF[rt], rd2=0, imm_value=ext(imm).
  - BR (0,0,1,0): rd1=RF[rs], rd2=RF[rt], imm_value=ext(imm).
  - ST (0,0,0,1): rd1=RF[rs], rd2=RF[rt], imm_value=ext(imm).
  - Any other pattern: rd1=rd2=imm_value=0; ctrl_out and valid_out still loaded.
- Write-back: on posedge with wb_we=1, RF[wb_addr]=wb_data. This is independent of stall and flush.
  - With ZERO_REG=1, writes to index 0 are dropped.
- Same-edge read and write to the same index without the bypass macro: the read returns the old value.
- stall and flush asserted together: flush wins.
- Extension: IMM_SIGNED=1 replicates imm[IMM_W-1]; otherwise pad with zeros.

Optional Feature:
- Macro: ID_EX_WB_BYPASS_EN.
- Defined: when wb_we=1 and wb_addr matches the rs/rt index being read on the same edge, the registered operand takes wb_data.
  - Exception: no bypass for index 0 when ZERO_REG=1.
- Undefined: no bypass; the old value is registered, and the hazard is the hazard unit's job.

Decomposition:
- Package id_ex_pkg:
  - ctrl bit index constants: REG_DST=7, JUMP=6, BRANCH=5, MEM_READ=4, MEM_TO_REG=3, MEM_WRITE=2, ALU_SRC=1, REG_WRITE=0.
  - instruction-class enum {CLS_R, CLS_I, CLS_BR, CLS_ST, CLS_NONE}.
  - a classify function.
- Sub-module regfile_2r1w (parametrised DATA_W, REG_ADDR_W, ZERO_REG):
  - async reset clear, combinational reads, synchronous write.
  - The top level owns decode, bypass and the pipeline register.

Test Plan:
- Reset mid-run: write RF[3]=0x55, assert rst between edges -> outputs 0 immediately; after release, an R read of rs=3 returns 0.
- R-type: RF[1]=10, RF[2]=20, ctrl_in=0x81, rs=1, rt=2 -> next edge read_data1=10, read_data2=20, valid_out=1.
- I-type with IMM_SIGNED=1, imm=0xF0, rt=4, RF[4]=7 -> read_data1=7, imm_value=0xFFFFFFF0, ctrl_out=0x01.
- Stall 3 cycles while the inputs change -> outputs frozen. Then flush+stall together -> valid_out=0, ctrl_out=0.
- Same-edge wb_we=1, wb_addr=5, wb_data=99 and ST read with rs=5 (old RF[5]=1) -> read_data1=99 with ID_EX_WB_BYPASS_EN, 1 without.
- ZERO_REG=1: write RF[0]=0x1234, then R read with rs=0 -> read_data1=0.
